prim_generic_rotshift_pipe: RTL
===============================

Name: prim_generic_rotshift_pipe

Overview:
Runtime-programmable, pipelined barrel rotator/shifter for the crypto datapaths (SHA-2, ChaCha, BLAKE). It generalises the fixed-position rotate to a runtime amount and five operation modes. Each pipeline stage resolves AmtBitsPerStage bits of the amount. Valid/ready handshake on both sides, with per-stage backpressure and bubble collapsing.

Parameters:
Width, 32, data width; must be a power of two, at least 2 (elaboration assertion)
AmtWidth, 8, width of amt_i; must be at least $clog2(Width) (assertion)
AmtBitsPerStage, 2, amount bits resolved per registered stage; range 1..$clog2(Width)
UserWidth, 1, sideband carried alongside data, unmodified

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous flush of all stages
in_valid_i  in  1  input beat valid
in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o
data_i  in  Width  operand
amt_i  in  AmtWidth  shift/rotate amount
mode_i  in  3  operation: 0 ROTR, 1 ROTL, 2 SHR, 3 SHL, 4 SAR, 5-7 PASS
user_i  in  UserWidth  sideband
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream ready
data_o  out  Width  result
user_o  out  UserWidth  sideband of the same beat

Behaviour:
- Definitions: L = $clog2(Width); S = ceil(L / AmtBitsPerStage) registered stages; latency is exactly S cycles with no stall (Width 32, defaults: L=5, S=3).
- Reset (rst_ni low, async): all stage valid bits 0; out_valid_o=0; data_o=0; user_o=0; in_ready_o=1 once out of reset. Data registers also reset to 0.
- Rotations (ROTR, ROTL): effective amount n = amt_i mod Width, i.e. amt_i[L-1:0]. ROTR gives (x>>n)|(x<<(Width-n)). ROTL gives (x<<n)|(x>>(Width-n)). n=0 returns x.
- Shifts (SHR, SHL, SAR): amount is the full amt_i value, not reduced.
  - amt_i >= Width: SHR/SHL give 0; SAR gives all copies of x[Width-1].
  - Otherwise standard logical or arithmetic shift.
- PASS (modes 5-7): data_o = data_i.
- Pipeline: stage k (0..S-1) holds {valid, partial data, remaining amount, mode, user}.
  - Stage k applies amount bits [k*AmtBitsPerStage +: AmtBitsPerStage], LSB group first. The last stage may resolve fewer bits.
  - Out-of-range shift detection and mode decode happen at capture into stage 0 and are carried as flags.
- Handshake: ready_k = !valid_k || ready_(k+1), with ready_S = out_ready_i; in_ready_o = ready_0.
  - Bubbles collapse: a stalled output does not block upstream stages that hold empty slots.
  - Accepts one beat per cycle at full throughput.
- Output stability: while out_valid_o && !out_ready_i, data_o, user_o and out_valid_o hold stable.
- in_valid_i may drop without acceptance; in_valid_i is ignored while in_ready_o=0 (data is not captured).
- clear_i: next cycle all valid bits are 0; a beat presented in the same cycle as clear_i is dropped. clear_i takes priority over acceptance. Data contents may stay stale.
- Reset mid-operation: all in-flight beats are discarded immediately; no output beat follows reset release without a new input.
- Ordering: results leave in acceptance order; user_o always matches its beat.

Test Plan:
- ROTR, data 0x80000001, amt 1 -> data_o 0xC0000000 exactly 3 cycles after acceptance (defaults, out_ready_i=1); ROTL, data 0x12345678, amt 4 -> 0x23456781.
- ROTR, data 0x12345678, amt 36 -> 0x81234567 (same as amt 4); ROTR amt 32 and amt 0 -> 0x12345678 unchanged.
- SHR, data 0xFFFFFFFF, amt 40 -> 0x00000000; SAR, data 0x80000000, amt 31 -> 0xFFFFFFFF; SAR amt 200 -> 0xFFFFFFFF; SHL, data 0x1, amt 31 -> 0x80000000; mode 6 -> data unchanged.
- Back-to-back 8 beats with user_i=0..7, out_ready_i toggled in a random pattern -> all 8 results in order with matching user_o, no drop or duplicate, data_o stable while stalled; with out_ready_i held 0, in_ready_o drops only after 3 beats are accepted.
- clear_i asserted with 3 beats in flight plus a beat offered the same cycle -> out_valid_o=0 next cycle, no ghost outputs; a fresh beat afterwards returns its result with 3-cycle latency.
- rst_ni pulsed low asynchronously mid-stream -> out_valid_o=0 and data_o=0 immediately; after release in_ready_o=1 and no output appears until new input; repeat with Width=64, AmtBitsPerStage=1 (S=6 latency) and the ROTR/SAR checks.

Source files
------------

// File: rtl/prim_generic_rotshift_pipe.sv
// prim_generic_rotshift_pipe: pipelined runtime barrel rotator/shifter with valid/ready flow control
module prim_generic_rotshift_pipe #(
    parameter int Width           = 32,
    parameter int AmtWidth        = 8,
    parameter int AmtBitsPerStage = 2,
    parameter int UserWidth       = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [Width-1:0]     data_i,
    input  logic [AmtWidth-1:0]  amt_i,
    input  logic [2:0]           mode_i,
    input  logic [UserWidth-1:0] user_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [Width-1:0]     data_o,
    output logic [UserWidth-1:0] user_o
);
    localparam int L  = $clog2(Width);
    localparam int B  = AmtBitsPerStage;
    localparam int S  = (L + B - 1) / B;
    localparam int CW = AmtWidth > 32 ? AmtWidth : 32;
    localparam logic [Width-1:0] ones = '1;

    if (Width < 2 || (Width & (Width - 1)) != 0) begin : g_bad_width
        $error("Width must be a power of two of at least 2");
    end
    if (AmtWidth < L) begin : g_bad_amt
        $error("AmtWidth must cover $clog2(Width)");
    end
    if (B < 1 || B > L) begin : g_bad_bps
        $error("AmtBitsPerStage must be in 1..$clog2(Width)");
    end

    logic                 v   [S];
    logic                 rdy [S+1];
    logic [Width-1:0]     d   [S];
    logic [L-1:0]         a   [S];
    logic [2:0]           m   [S];
    logic [UserWidth-1:0] u   [S];
    logic                 oor;
    logic [Width-1:0]     cap_d;
    logic [2:0]           cap_m;

    // Resolve amount bits owned by stage k; only bits below L can ever be set.
    function automatic logic [Width-1:0] step(input logic [Width-1:0] x, input logic [2:0] op,
                                              input logic [L-1:0] amt, input int k);
        logic [Width-1:0] r;
        logic [L-1:0]     t;
        int               sh;
        r = x;
        for (int j = 0; j < B; j++) begin
            t  = amt >> (k * B + j);
            sh = 1 << (k * B + j);
            if (t[0]) r = op == 3'd0 ? (r >> sh) | (r << (Width - sh)) :
                          op == 3'd1 ? (r << sh) | (r >> (Width - sh)) :
                          op == 3'd2 ? r >> sh :
                          op == 3'd3 ? r << sh :
                          op == 3'd4 ? (r >> sh) | (~(ones >> sh) & {Width{r[Width-1]}}) : r;
        end
        return r;
    endfunction

    // Out-of-range shifts are finished at capture and then travel as a plain pass-through.
    assign oor   = (mode_i == 3'd2 || mode_i == 3'd3 || mode_i == 3'd4) && CW'(amt_i) >= CW'(Width);
    assign cap_d = !oor ? data_i : mode_i == 3'd4 ? {Width{data_i[Width-1]}} : '0;
    assign cap_m = oor ? 3'd5 : mode_i;

    // Ready ripples back from the output so empty slots keep absorbing beats during a stall.
    always_comb begin
        rdy[S] = out_ready_i;
        for (int i = S - 1; i >= 0; i--) rdy[i] = !v[i] || rdy[i+1];
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        logic                 pv;
        logic [Width-1:0]     pd;
        logic [L-1:0]         pa;
        logic [2:0]           pm;
        logic [UserWidth-1:0] pu;
        if (k == 0) begin : g_head
            assign pv = in_valid_i;
            assign pd = cap_d;
            assign pa = amt_i[L-1:0];
            assign pm = cap_m;
            assign pu = user_i;
        end else begin : g_body
            assign pv = v[k-1];
            assign pd = d[k-1];
            assign pa = a[k-1];
            assign pm = m[k-1];
            assign pu = u[k-1];
        end
        // Slot occupancy; clear wins over any movement into the slot.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) v[k] <= 1'b0;
            else if (clear_i) v[k] <= 1'b0;
            else if (rdy[k]) v[k] <= pv;
        end
        // Payload loads only when a real beat moves in, so a stalled output holds still.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                d[k] <= '0;
                a[k] <= '0;
                m[k] <= '0;
                u[k] <= '0;
            end else if (rdy[k] && pv && !clear_i) begin
                d[k] <= step(pd, pm, pa, k);
                a[k] <= pa;
                m[k] <= pm;
                u[k] <= pu;
            end
        end
    end

    assign in_ready_o  = rdy[0];
    assign out_valid_o = v[S-1];
    assign data_o      = d[S-1];
    assign user_o      = u[S-1];
endmodule
